// File: rtl/regfile_pkg.sv
// Shared address map, storage indexing and decode helper for the multi-port register file.
package regfile_pkg;

    localparam logic [6:0]  ADDR_HI = 7'h7F;
    localparam logic [6:0]  ADDR_LO = 7'h40;
    localparam int unsigned CP0_BIT = 5;
    localparam int unsigned HL_BIT  = 6;

    localparam int unsigned IDX_W   = 6;
    localparam int unsigned NUM_IDX = 34;
    localparam logic [IDX_W-1:0] IDX_HI = 6'd32;
    localparam logic [IDX_W-1:0] IDX_LO = 6'd33;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } reg_idx_t;

    // GPR0 decodes to index 0 but is marked invalid: it has neither storage nor a counter.
    function automatic reg_idx_t addr_to_idx(input logic [6:0] addr);
        reg_idx_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        if (addr == ADDR_HI) begin
            r.valid = 1'b1;
            r.idx   = IDX_HI;
        end else if (addr == ADDR_LO) begin
            r.valid = 1'b1;
            r.idx   = IDX_LO;
        end else if (!addr[HL_BIT] && !addr[CP0_BIT]) begin
            r.idx   = {1'b0, addr[4:0]};
            r.valid = (addr[4:0] != 5'd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Outstanding-producer counter for one register: +1 on issue, -N on writeback hits,
// clamped at zero with an underflow flag when the clamp is needed.
module regfile_pend_ctr #(
    parameter int unsigned PEND_W = 2,
    parameter int unsigned DEC_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic [DEC_W-1:0]  dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              nxt_zero_o,
    output logic              uf_o
);

    localparam int unsigned SW = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     avail, take;

    always_comb begin
        avail = SW'(cnt_q) + SW'(inc_i);
        take  = SW'(dec_i);
        uf_o  = (take > avail);
        cnt_d = uf_o ? '0 : PEND_W'(avail - take);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign nxt_zero_o = (cnt_d == '0);

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported GPR + HI/LO register file with write bypass, write-port priority
// and a per-register outstanding-producer scoreboard gating issue.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_READ  = 4,
    parameter int unsigned NUM_WRITE = 2,
    parameter int unsigned PEND_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WRITE-1:0]    regwrite,
    input  logic [7*NUM_WRITE-1:0]  write_addr,
    input  logic [32*NUM_WRITE-1:0] write_data,
    input  logic                    hl_write_enable_from_wb,
    input  logic [63:0]             hl_data,
    input  logic [7*NUM_READ-1:0]   read_addr,
    output logic [32*NUM_READ-1:0]  read_data,
    output logic [NUM_READ-1:0]     read_busy,
    input  logic                    iss_valid,
    input  logic [6:0]              iss_addr,
    input  logic                    iss_hl,
    output logic                    iss_ready,
    output logic                    pend_err
);

    localparam int unsigned      DEC_W    = $clog2(NUM_WRITE + 2);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    reg_idx_t             wr_dec [NUM_WRITE];
    logic [NUM_WRITE-1:0] wr_ok;

    logic [31:0]          data_q   [1:NUM_IDX-1];
    logic [31:0]          data_d   [1:NUM_IDX-1];
    logic [NUM_IDX-1:1]   wr_hit;
    logic [DEC_W-1:0]     dec_cnt  [1:NUM_IDX-1];

    logic [PEND_W-1:0]    cnt      [1:NUM_IDX-1];
    logic [NUM_IDX-1:1]   nxt_zero;
    logic [NUM_IDX-1:1]   uf;
    logic [NUM_IDX-1:1]   inc;
    logic [NUM_IDX-1:1]   iss_tgt;
    logic                 iss_full;
    reg_idx_t             iss_dec;

    logic                 pend_err_q, pend_err_d;

    for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wdec
        assign wr_dec[k] = addr_to_idx(write_addr[7*k +: 7]);
        assign wr_ok[k]  = regwrite[k] && wr_dec[k].valid;
    end

    // data_d doubles as the bypass value: later ports overwrite earlier ones, HL port last.
    always_comb begin
        for (int unsigned i = 1; i < NUM_IDX; i++) begin
            wr_hit[i]  = 1'b0;
            data_d[i]  = data_q[i];
            dec_cnt[i] = '0;
            for (int unsigned k = 0; k < NUM_WRITE; k++) begin
                if (wr_ok[k] && (wr_dec[k].idx == IDX_W'(i))) begin
                    wr_hit[i]  = 1'b1;
                    data_d[i]  = write_data[32*k +: 32];
                    dec_cnt[i] = dec_cnt[i] + DEC_W'(1);
                end
            end
            if (hl_write_enable_from_wb &&
                ((IDX_W'(i) == IDX_HI) || (IDX_W'(i) == IDX_LO))) begin
                wr_hit[i]  = 1'b1;
                data_d[i]  = (IDX_W'(i) == IDX_HI) ? hl_data[63:32] : hl_data[31:0];
                dec_cnt[i] = dec_cnt[i] + DEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 1; i < NUM_IDX; i++) begin
            if (rst) begin
                data_q[i] <= '0;
            end else begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        iss_dec  = addr_to_idx(iss_addr);
        iss_full = 1'b0;
        for (int unsigned i = 1; i < NUM_IDX; i++) begin
            if (iss_hl) begin
                iss_tgt[i] = (IDX_W'(i) == IDX_HI) || (IDX_W'(i) == IDX_LO);
            end else begin
                iss_tgt[i] = iss_dec.valid && (iss_dec.idx == IDX_W'(i));
            end
            if (iss_tgt[i] && (cnt[i] == PEND_MAX)) begin
                iss_full = 1'b1;
            end
        end
        iss_ready = iss_valid && (rst || !iss_full);
        for (int unsigned i = 1; i < NUM_IDX; i++) begin
            inc[i] = iss_tgt[i] && iss_ready && !rst;
        end
    end

    for (genvar g = 1; g < NUM_IDX; g++) begin : g_ctr
        regfile_pend_ctr #(
            .PEND_W (PEND_W),
            .DEC_W  (DEC_W)
        ) u_ctr (
            .clk_i      (clk),
            .rst_i      (rst),
            .inc_i      (inc[g]),
            .dec_i      (dec_cnt[g]),
            .cnt_o      (cnt[g]),
            .nxt_zero_o (nxt_zero[g]),
            .uf_o       (uf[g])
        );
    end

    for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
        reg_idx_t    rd_dec;
        logic [31:0] rd_val;
        logic        rd_bsy;

        assign rd_dec = addr_to_idx(read_addr[7*j +: 7]);

        // Busy clears in the cycle whose writeback leaves the counter at zero.
        always_comb begin
            rd_val = '0;
            rd_bsy = 1'b0;
            for (int unsigned i = 1; i < NUM_IDX; i++) begin
                if (rd_dec.valid && (rd_dec.idx == IDX_W'(i))) begin
                    if (!rst || wr_hit[i]) begin
                        rd_val = data_d[i];
                    end
                    rd_bsy = !rst && (cnt[i] != '0) && !nxt_zero[i];
                end
            end
        end

        assign read_data[32*j +: 32] = rd_val;
        assign read_busy[j]          = rd_bsy;
    end

    assign pend_err_d = pend_err_q | (|uf);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_err_q <= 1'b0;
        end else begin
            pend_err_q <= pend_err_d;
        end
    end

    assign pend_err = pend_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scenario-driven bench for regfile_mp: expectations are queued as stimulus is applied
// and drained against the DUT before the next clock edge.
module tb_regfile_mp;

    localparam int NR = 4;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NW-1:0]   regwrite;
    logic [7*NW-1:0] write_addr;
    logic [32*NW-1:0] write_data;
    logic            hl_write_enable_from_wb;
    logic [63:0]     hl_data;
    logic [7*NR-1:0] read_addr;
    logic [32*NR-1:0] read_data;
    logic [NR-1:0]   read_busy;
    logic            iss_valid;
    logic [6:0]      iss_addr;
    logic            iss_hl;
    logic            iss_ready;
    logic            pend_err;

    always #5 clk = ~clk;

    regfile_mp #(
        .NUM_READ  (NR),
        .NUM_WRITE (NW),
        .PEND_W    (2)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .regwrite                (regwrite),
        .write_addr              (write_addr),
        .write_data              (write_data),
        .hl_write_enable_from_wb (hl_write_enable_from_wb),
        .hl_data                 (hl_data),
        .read_addr               (read_addr),
        .read_data               (read_data),
        .read_busy               (read_busy),
        .iss_valid               (iss_valid),
        .iss_addr                (iss_addr),
        .iss_hl                  (iss_hl),
        .iss_ready               (iss_ready),
        .pend_err                (pend_err)
    );

    // kind: 0 read_data[port], 1 read_busy[port], 2 iss_ready, 3 pend_err
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input int kind, input int port);
        case (kind)
            0:       return read_data[32*port +: 32];
            1:       return {31'b0, read_busy[port]};
            2:       return {31'b0, iss_ready};
            default: return {31'b0, pend_err};
        endcase
    endfunction

    task automatic push(input string name, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic idle();
        rst = 1'b0;
        regwrite = '0;
        write_addr = '0;
        write_data = '0;
        hl_write_enable_from_wb = 1'b0;
        hl_data = '0;
        read_addr = '0;
        iss_valid = 1'b0;
        iss_addr = '0;
        iss_hl = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [6:0] a);
        read_addr[7*p +: 7] = a;
    endtask

    task automatic set_wr(input int p, input logic [6:0] a, input logic [31:0] d);
        regwrite[p] = 1'b1;
        write_addr[7*p +: 7] = a;
        write_data[32*p +: 32] = d;
    endtask

    task automatic set_iss(input logic [6:0] a);
        iss_valid = 1'b1;
        iss_addr = a;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            idle();
            case (s)
                0: begin
                    rst = 1'b1;
                    set_iss(7'd7);
                    set_rd(0, 7'd5);
                    set_rd(1, 7'h7F);
                    push("rst_rd_r5", 0, 0, 32'h0);
                    push("rst_busy_r5", 1, 0, 32'h0);
                    push("rst_rd_hi", 0, 1, 32'h0);
                    push("rst_iss_ready", 2, 0, 32'h1);
                end
                default: begin
                    set_rd(0, 7'd5);
                    set_rd(1, 7'h40);
                    set_rd(2, 7'h1F);
                    push("post_rst_r5", 0, 0, 32'h0);
                    push("post_rst_lo", 0, 1, 32'h0);
                    push("post_rst_r31", 0, 2, 32'h0);
                    push("post_rst_busy", 1, 0, 32'h0);
                    push("post_rst_pend_err", 3, 0, 32'h0);
                end
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_dual_write();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            idle();
            if (s == 0) begin
                set_wr(0, 7'd5, 32'h1111);
                set_wr(1, 7'd5, 32'h2222);
                set_rd(0, 7'd5);
                push("dual_byp_r5", 0, 0, 32'h2222);
            end else begin
                set_rd(0, 7'd5);
                set_rd(3, 7'd5);
                push("dual_stored_p0", 0, 0, 32'h2222);
                push("dual_stored_p3", 0, 3, 32'h2222);
            end
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_hilo();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            idle();
            if (s == 0) begin
                hl_write_enable_from_wb = 1'b1;
                hl_data = 64'hAAAA_BBBB_CCCC_DDDD;
                set_wr(1, 7'h7F, 32'h1234);
            end
            set_rd(0, 7'h7F);
            set_rd(1, 7'h40);
            push(s == 0 ? "hl_byp_hi" : "hl_stored_hi", 0, 0, 32'hAAAA_BBBB);
            push(s == 0 ? "hl_byp_lo" : "hl_stored_lo", 0, 1, 32'hCCCC_DDDD);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_zero_cp0();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            idle();
            if (s == 0) begin
                set_wr(0, 7'd0, 32'hDEAD_BEEF);
                set_wr(1, 7'h21, 32'hCAFE_F00D);
                set_iss(7'd0);
                push("r0_iss_ready", 2, 0, 32'h1);
                push("r0_busy", 1, 0, 32'h0);
                push("cp0_busy", 1, 1, 32'h0);
            end
            set_rd(0, 7'd0);
            set_rd(1, 7'h21);
            push("r0_read", 0, 0, 32'h0);
            push("cp0_read", 0, 1, 32'h0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] wb_val;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            idle();
            set_rd(0, 7'd7);
            if (s < 4) begin
                set_iss(7'd7);
                push("sb_iss_ready", 2, 0, (s < 3) ? 32'h1 : 32'h0);
                push("sb_busy_issue", 1, 0, (s == 0) ? 32'h0 : 32'h1);
            end else if (s < 7) begin
                wb_val = 32'h70 + 32'(s - 3);
                set_wr(s % 2, 7'd7, wb_val);
                push("sb_busy_wb", 1, 0, (s < 6) ? 32'h1 : 32'h0);
                push("sb_byp_wb", 0, 0, wb_val);
            end else begin
                push("sb_busy_after", 1, 0, 32'h0);
                push("sb_data_after", 0, 0, 32'h73);
            end
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            idle();
            set_rd(0, 7'd9);
            case (s)
                0: begin
                    set_iss(7'd9);
                    push("sim_first_iss", 2, 0, 32'h1);
                end
                1: begin
                    set_iss(7'd9);
                    set_wr(0, 7'd9, 32'h99);
                    push("sim_iss_ready", 2, 0, 32'h1);
                    push("sim_busy_same", 1, 0, 32'h1);
                    push("sim_byp", 0, 0, 32'h99);
                end
                2: push("sim_busy_next", 1, 0, 32'h1);
                3: begin
                    set_wr(1, 7'd9, 32'h9A);
                    push("sim_busy_retire", 1, 0, 32'h0);
                    push("sim_byp_retire", 0, 0, 32'h9A);
                end
                default: push("sim_busy_idle", 1, 0, 32'h0);
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_underflow();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            idle();
            case (s)
                0: rst = 1'b1;
                1: begin
                    set_wr(0, 7'd3, 32'h33);
                    set_rd(0, 7'd3);
                    push("uf_pend_err_before", 3, 0, 32'h0);
                    push("uf_byp_r3", 0, 0, 32'h33);
                end
                default: push("uf_pend_err_sticky", 3, 0, 32'h1);
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            idle();
            set_rd(0, 7'd10);
            set_rd(1, 7'd11);
            set_rd(2, 7'd12);
            set_rd(3, 7'd13);
            case (s)
                0, 1: set_iss(7'd10);
                2: begin
                    set_iss(7'd11);
                    set_wr(0, 7'd12, 32'hABC);
                end
                3: begin
                    push("mr_busy_r10", 1, 0, 32'h1);
                    push("mr_busy_r11", 1, 1, 32'h1);
                    push("mr_data_r12", 0, 2, 32'hABC);
                    push("mr_pend_err_set", 3, 0, 32'h1);
                end
                4: begin
                    rst = 1'b1;
                    set_wr(1, 7'd13, 32'h1313);
                    push("mr_in_rst_busy_r10", 1, 0, 32'h0);
                    push("mr_in_rst_busy_r11", 1, 1, 32'h0);
                    push("mr_in_rst_r12", 0, 2, 32'h0);
                    push("mr_in_rst_byp_r13", 0, 3, 32'h1313);
                end
                5: begin
                    push("mr_post_busy_r10", 1, 0, 32'h0);
                    push("mr_post_busy_r11", 1, 1, 32'h0);
                    push("mr_post_r10", 0, 0, 32'h0);
                    push("mr_post_r12", 0, 2, 32'h0);
                    push("mr_post_r13", 0, 3, 32'h0);
                    push("mr_post_pend_err", 3, 0, 32'h0);
                end
                6: begin
                    set_wr(0, 7'd10, 32'h10);
                    push("mr_wb_pend_err_same", 3, 0, 32'h0);
                end
                default: push("mr_wb_pend_err_next", 3, 0, 32'h1);
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_dual_write();
        test_hilo();
        test_zero_cp0();
        test_scoreboard();
        test_simultaneous();
        test_underflow();
        test_mid_reset();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
